// File: rtl/noc_params.sv
// Shared NoC types for the router input port: flit format, labels, ports, VC FSM states.
// Optional error tracking in vc_input_port is enabled by VC_INPUT_PORT_ERR_CHECK_EN.
package noc_params;

  localparam int VC_NUM  = 2;
  localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DATA_W  = 16;

  typedef enum logic [1:0] {
    HEAD,
    BODY,
    TAIL,
    HEADTAIL
  } flit_label_t;

  typedef enum logic [2:0] {
    LOCAL,
    NORTH,
    SOUTH,
    WEST,
    EAST
  } port_t;

  typedef enum logic [1:0] {
    IDLE,
    VA,
    SA
  } vc_state_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    logic [DATA_W-1:0]  data;
  } flit_t;

  function automatic logic is_head(input flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_label_t l);
    return (l == TAIL) || (l == HEADTAIL);
  endfunction

endpackage

// File: rtl/vc_input_port_if.sv
// Link/allocator-side bundle of the VC input port.
// slave is the port itself, master is whoever drives the link and allocators.
interface vc_input_port_if
  #(parameter int VC_NUM = noc_params::VC_NUM);
  import noc_params::*;

  flit_t                           data_i;
  logic                            valid_flit_i;
  port_t                           out_port_i;
  logic [VC_NUM-1:0]               read_i;
  logic [VC_NUM-1:0]               vc_valid_i;
  logic [VC_NUM-1:0][VC_SIZE-1:0]  vc_new_i;

  flit_t                           data_o;
  logic                            valid_o;
  logic [VC_NUM-1:0]               va_request_o;
  logic [VC_NUM-1:0]               sa_request_o;
  port_t [VC_NUM-1:0]              out_port_o;
  logic [VC_NUM-1:0]               is_full_o;
  logic [VC_NUM-1:0]               is_empty_o;
  logic [VC_NUM-1:0]               error_o;

  modport slave (
    input  data_i, valid_flit_i, out_port_i,
    input  read_i, vc_valid_i, vc_new_i,
    output data_o, valid_o, va_request_o,
    output sa_request_o, out_port_o,
    output is_full_o, is_empty_o, error_o
  );

  modport master (
    output data_i, valid_flit_i, out_port_i,
    output read_i, vc_valid_i, vc_new_i,
    input  data_o, valid_o, va_request_o,
    input  sa_request_o, out_port_o,
    input  is_full_o, is_empty_o, error_o
  );

endinterface

// File: rtl/vc_input_port_fifo.sv
// Per-VC flit FIFO; pop on empty and push on full (without pop) are ignored.
// Pointers wrap naturally, so BUFFER_SIZE must be a power of two.
module vc_fifo
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  flit_t wdata,
  output flit_t head,
  output logic  full,
  output logic  empty
);

  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  flit_t          mem [BUFFER_SIZE];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(BUFFER_SIZE));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  // flit storage, contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vc_input_port.sv
// Router input port: VC_NUM FIFOs, per-VC IDLE/VA/SA FSM, route and downstream VC latch.
// Define VC_INPUT_PORT_ERR_CHECK_EN for sticky per-VC protocol error flags.
module vc_input_port
  import noc_params::*;
#(
  parameter int VC_NUM      = noc_params::VC_NUM,
  parameter int BUFFER_SIZE = 8
) (
  input logic           clk,
  input logic           rst,
  vc_input_port_if.slave bus
);

  vc_state_t [VC_NUM-1:0]          state;
  vc_state_t [VC_NUM-1:0]          state_nxt;
  flit_t [VC_NUM-1:0]              head;
  port_t [VC_NUM-1:0]              route;
  logic [VC_NUM-1:0][VC_SIZE-1:0]  dvc;
  logic [VC_NUM-1:0]               full;
  logic [VC_NUM-1:0]               empty;
  logic [VC_NUM-1:0]               wr_sel;
  logic [VC_NUM-1:0]               label_ok;
  logic [VC_NUM-1:0]               push;
  logic [VC_NUM-1:0]               pop;
  logic [VC_NUM-1:0]               rd_eff;
  logic [VC_NUM-1:0]               va_req;
  logic [VC_NUM-1:0]               sa_req;
  logic                            hd_in;
  logic                            rd_onehot0;
  flit_t                           out_flit;
  logic                            out_vld;

  assign hd_in      = is_head(bus.data_i.flit_label);
  assign rd_onehot0 =
    (bus.read_i & (bus.read_i - VC_NUM'(1))) == '0;

`ifdef VC_INPUT_PORT_ERR_CHECK_EN
  assign rd_eff = rd_onehot0 ? bus.read_i : '0;
`else
  assign rd_eff = bus.read_i & (~bus.read_i + VC_NUM'(1));
`endif

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign wr_sel[v] = bus.valid_flit_i &&
      (bus.data_i.vc_id == VC_SIZE'(v));
    assign label_ok[v] = hd_in ? (state[v] == IDLE)
                               : (state[v] != IDLE);
    assign pop[v] = rd_eff[v] && (state[v] == SA) && !empty[v];
    assign push[v] = wr_sel[v] && label_ok[v] &&
      (!full[v] || pop[v]);

    vc_fifo #(
      .BUFFER_SIZE(BUFFER_SIZE)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[v]),
      .pop   (pop[v]),
      .wdata (bus.data_i),
      .head  (head[v]),
      .full  (full[v]),
      .empty (empty[v])
    );
  end

  // per-VC packet state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VC_NUM; i++) state[i] <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // per-VC packet state transitions
  always_comb begin
    state_nxt = state;
    for (int i = 0; i < VC_NUM; i++) begin
      unique case (state[i])
        IDLE:    if (push[i]) state_nxt[i] = VA;
        VA:      if (bus.vc_valid_i[i]) state_nxt[i] = SA;
        SA:      if (pop[i] && is_tail(head[i].flit_label))
                   state_nxt[i] = IDLE;
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // allocator requests decoded from state
  always_comb begin
    va_req = '0;
    sa_req = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      va_req[i] = (state[i] == VA);
      sa_req[i] = (state[i] == SA) && !empty[i];
    end
  end

  // route latched on packet start, downstream VC on VA grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VC_NUM; i++) begin
        route[i] <= LOCAL;
        dvc[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < VC_NUM; i++) begin
        if (push[i] && state[i] == IDLE)
          route[i] <= bus.out_port_i;
        if (state[i] == VA && bus.vc_valid_i[i])
          dvc[i] <= bus.vc_new_i[i];
      end
    end
  end

  // popped flit with vc_id rewritten to the downstream VC
  always_comb begin
    out_flit = '0;
    out_vld  = 1'b0;
    for (int i = 0; i < VC_NUM; i++) begin
      if (pop[i]) begin
        out_vld        = 1'b1;
        out_flit       = head[i];
        out_flit.vc_id = dvc[i];
      end
    end
  end

`ifdef VC_INPUT_PORT_ERR_CHECK_EN
  logic [VC_NUM-1:0] err;

  // sticky flag for dropped writes and ignored reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= '0;
    else      err <= err | (wr_sel & ~push) | (bus.read_i & ~pop);
  end

  assign bus.error_o = err;
`else
  assign bus.error_o = '0;
`endif

  assign bus.data_o       = out_flit;
  assign bus.valid_o      = out_vld;
  assign bus.va_request_o = va_req;
  assign bus.sa_request_o = sa_req;
  assign bus.out_port_o   = route;
  assign bus.is_full_o    = full;
  assign bus.is_empty_o   = empty;

endmodule

// File: tb/tb_vc_input_port.sv
// Directed bench for vc_input_port (2 VCs, 8-deep FIFOs).
// Error expectations follow VC_INPUT_PORT_ERR_CHECK_EN.
module tb_vc_input_port;
  import noc_params::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vc_input_port_if #(.VC_NUM(2)) bus ();

  vc_input_port #(
    .VC_NUM(2),
    .BUFFER_SIZE(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef VC_INPUT_PORT_ERR_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fl(input flit_label_t l,
                                     input logic [VC_SIZE-1:0] vc,
                                     input logic [15:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = vc;
    f.data       = d;
    return 32'(f);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    bus.valid_flit_i = 1'b0;
    bus.read_i       = '0;
    bus.vc_valid_i   = '0;
  endtask

  task automatic put(input int vc, input flit_label_t l,
                     input port_t p, input logic [15:0] d);
    bus.data_i.flit_label = l;
    bus.data_i.vc_id      = VC_SIZE'(vc);
    bus.data_i.data       = d;
    bus.out_port_i        = p;
    bus.valid_flit_i      = 1'b1;
  endtask

  task automatic grant(input int vc, input logic [VC_SIZE-1:0] nv);
    bus.vc_valid_i[vc] = 1'b1;
    bus.vc_new_i[vc]   = nv;
  endtask

  task automatic pop_chk(input string tag, input int vc,
                         input logic [31:0] exp);
    bus.read_i     = '0;
    bus.read_i[vc] = 1'b1;
    #1;
    check({tag, "_vld"}, 32'(bus.valid_o), 32'd1);
    check(tag, 32'(bus.data_o), exp);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("rst_err", 32'(bus.error_o), 32'd0);
    check("rst_empty", 32'(bus.is_empty_o), 32'd3);
  endtask

  logic [31:0] exp_il [4];
  int          vc_il [4];

  initial begin
    bus.data_i       = '0;
    bus.valid_flit_i = 1'b0;
    bus.out_port_i   = LOCAL;
    bus.read_i       = '0;
    bus.vc_valid_i   = '0;
    bus.vc_new_i     = '0;
    #2;
    check("r_empty", 32'(bus.is_empty_o), 32'd3);
    check("r_full", 32'(bus.is_full_o), 32'd0);
    check("r_va", 32'(bus.va_request_o), 32'd0);
    check("r_sa", 32'(bus.sa_request_o), 32'd0);
    check("r_vld", 32'(bus.valid_o), 32'd0);
    check("r_data", 32'(bus.data_o), 32'd0);
    check("r_err", 32'(bus.error_o), 32'd0);
    check("r_port0", 32'(bus.out_port_o[0]), 32'(LOCAL));
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // 1: reset in mid-packet
    put(0, HEAD, EAST, 16'h0010);
    tick();
    check("t1_va", 32'(bus.va_request_o), 32'd1);
    check("t1_port", 32'(bus.out_port_o[0]), 32'(EAST));
    check("t1_nempty", 32'(bus.is_empty_o), 32'd2);
    rst = 1'b0;
    #1;
    check("t1_rva", 32'(bus.va_request_o), 32'd0);
    check("t1_rempty", 32'(bus.is_empty_o), 32'd3);
    check("t1_rport", 32'(bus.out_port_o[0]), 32'(LOCAL));
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    put(0, HEADTAIL, NORTH, 16'h0011);
    tick();
    check("t1_va2", 32'(bus.va_request_o), 32'd1);
    check("t1_port2", 32'(bus.out_port_o[0]), 32'(NORTH));
    grant(0, 1'b1);
    tick();
    check("t1_sa", 32'(bus.sa_request_o), 32'd1);
    pop_chk("t1_pop", 0, fl(HEADTAIL, 1'b1, 16'h0011));
    check("t1_idle_sa", 32'(bus.sa_request_o), 32'd0);
    check("t1_idle_va", 32'(bus.va_request_o), 32'd0);

    // 2: single packet on VC1
    put(1, HEAD, EAST, 16'h0022);
    tick();
    check("t2_va", 32'(bus.va_request_o), 32'd2);
    check("t2_port", 32'(bus.out_port_o[1]), 32'(EAST));
    put(1, BODY, LOCAL, 16'h0023);
    tick();
    put(1, TAIL, LOCAL, 16'h0024);
    tick();
    check("t2_sa0", 32'(bus.sa_request_o), 32'd0);
    grant(1, 1'b0);
    tick();
    check("t2_sa", 32'(bus.sa_request_o), 32'd2);
    check("t2_va0", 32'(bus.va_request_o), 32'd0);
    pop_chk("t2_p0", 1, fl(HEAD, 1'b0, 16'h0022));
    pop_chk("t2_p1", 1, fl(BODY, 1'b0, 16'h0023));
    pop_chk("t2_p2", 1, fl(TAIL, 1'b0, 16'h0024));
    check("t2_empty", 32'(bus.is_empty_o), 32'd3);
    check("t2_sa_end", 32'(bus.sa_request_o), 32'd0);
    put(1, HEAD, WEST, 16'h0025);
    tick();
    check("t2_idle", 32'(bus.va_request_o), 32'd2);
    do_reset();

    // 3: interleaved packets
    put(0, HEAD, WEST, 16'h00A0);
    tick();
    put(1, HEAD, SOUTH, 16'h00B0);
    tick();
    put(0, TAIL, LOCAL, 16'h00A1);
    tick();
    put(1, TAIL, LOCAL, 16'h00B1);
    tick();
    grant(0, 1'b1);
    grant(1, 1'b0);
    tick();
    check("t3_sa", 32'(bus.sa_request_o), 32'd3);
    check("t3_port0", 32'(bus.out_port_o[0]), 32'(WEST));
    check("t3_port1", 32'(bus.out_port_o[1]), 32'(SOUTH));
    exp_il[0] = fl(HEAD, 1'b1, 16'h00A0); vc_il[0] = 0;
    exp_il[1] = fl(HEAD, 1'b0, 16'h00B0); vc_il[1] = 1;
    exp_il[2] = fl(TAIL, 1'b1, 16'h00A1); vc_il[2] = 0;
    exp_il[3] = fl(TAIL, 1'b0, 16'h00B1); vc_il[3] = 1;
    for (int i = 0; i < 4; i++) pop_chk("t3_pop", vc_il[i], exp_il[i]);
    check("t3_empty", 32'(bus.is_empty_o), 32'd3);
    check("t3_sa_end", 32'(bus.sa_request_o), 32'd0);

    // 4: full VC0
    put(0, HEAD, EAST, 16'h0040);
    tick();
    for (int i = 1; i < 8; i++) begin
      put(0, BODY, LOCAL, 16'h0040 + 16'(i));
      tick();
    end
    check("t4_full", 32'(bus.is_full_o), 32'd1);
    check("t4_err0", 32'(bus.error_o), 32'd0);
    put(0, BODY, LOCAL, 16'h0048);
    tick();
    check("t4_full9", 32'(bus.is_full_o), 32'd1);
    check("t4_err", 32'(bus.error_o), EN ? 32'd1 : 32'd0);
    grant(0, 1'b1);
    tick();
    check("t4_sa", 32'(bus.sa_request_o), 32'd1);
    put(0, BODY, LOCAL, 16'h0099);
    pop_chk("t4_wr_rd", 0, fl(HEAD, 1'b1, 16'h0040));
    check("t4_full2", 32'(bus.is_full_o), 32'd1);
    for (int i = 1; i < 8; i++)
      pop_chk("t4_drain", 0, fl(BODY, 1'b1, 16'h0040 + 16'(i)));
    pop_chk("t4_last", 0, fl(BODY, 1'b1, 16'h0099));
    check("t4_empty", 32'(bus.is_empty_o), 32'd3);
    check("t4_sa_e", 32'(bus.sa_request_o), 32'd0);
    do_reset();

    // 5: HEADTAIL and HEAD into a VC in SA
    put(1, HEADTAIL, NORTH, 16'h0055);
    tick();
    check("t5_va", 32'(bus.va_request_o), 32'd2);
    grant(1, 1'b1);
    tick();
    check("t5_sa", 32'(bus.sa_request_o), 32'd2);
    put(1, HEAD, EAST, 16'h0066);
    tick();
    check("t5_err", 32'(bus.error_o), EN ? 32'd2 : 32'd0);
    check("t5_port", 32'(bus.out_port_o[1]), 32'(NORTH));
    pop_chk("t5_pop", 1, fl(HEADTAIL, 1'b1, 16'h0055));
    check("t5_empty", 32'(bus.is_empty_o), 32'd3);
    check("t5_sa_e", 32'(bus.sa_request_o), 32'd0);
    do_reset();

    // 6: illegal reads
    put(0, HEAD, SOUTH, 16'h0070);
    tick();
    bus.read_i = 2'b01;
    #1;
    check("t6_va_vld", 32'(bus.valid_o), 32'd0);
    tick();
    check("t6_va_err", 32'(bus.error_o), EN ? 32'd1 : 32'd0);
    check("t6_va_emp", 32'(bus.is_empty_o), 32'd2);
    grant(0, 1'b0);
    tick();
    put(1, HEADTAIL, NORTH, 16'h0071);
    tick();
    grant(1, 1'b1);
    tick();
    check("t6_sa", 32'(bus.sa_request_o), 32'd3);
    bus.read_i = 2'b11;
    #1;
    check("t6_11_vld", 32'(bus.valid_o), EN ? 32'd0 : 32'd1);
    check("t6_11_dat", 32'(bus.data_o),
          EN ? 32'd0 : fl(HEAD, 1'b0, 16'h0070));
    tick();
    check("t6_11_err", 32'(bus.error_o), EN ? 32'd3 : 32'd0);
    check("t6_11_emp", 32'(bus.is_empty_o), EN ? 32'd0 : 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
